wb_apb_bridge: RTL and testbench

//  Wishbone B4 pipelined slave to APB4 master bridge; sits directly upstream of the

---
 rtl/wb_apb_bridge_pkg.sv | 17 +
 rtl/apb_timeout_cnt.sv | 40 ++++
 rtl/wb_apb_bridge.sv | 172 +++++++++++++++++
 tb/tb_wb_apb_bridge.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_apb_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-APB bridge.
package wb_apb_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } state_e;

  localparam logic [3:0] PSTRB_READ = 4'b0000;

  // A TIMEOUT of 0 still needs a 1-bit counter so the port widths stay legal.
  function automatic int cnt_width(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// Bounded-wait counter for the APB ACCESS phase; a zero limit never expires.
module apb_timeout_cnt #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH:0]   cnt_inc;

  // One extra bit on the increment so comparing against the limit never wraps.
  assign cnt_inc   = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
  assign expired_o = en_i && (limit_i != {WIDTH{1'b0}}) && (cnt_inc >= {1'b0, limit_i});

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = {WIDTH{1'b0}};
    end else if (en_i) begin
      cnt_d = cnt_inc[WIDTH-1:0];
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {WIDTH{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_apb_bridge.sv
// Wishbone B4 pipelined slave to APB4 master, one transfer in flight, with an
// ACCESS-phase timeout so an unresponsive slave turns into wb_err_o.
module wb_apb_bridge
  import wb_apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [ADDR_WIDTH-1:0] wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_stall_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pwdata,
  output logic [3:0]            pstrb,
  input  logic                  pready,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pslverr
);

  localparam int               CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT);

  state_e                state_q, state_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  stall_q;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  abort_q, abort_d;
  logic                  to_clear_s;
  logic                  to_en_s;
  logic                  to_expired_s;

  apb_timeout_cnt #(.WIDTH(CNT_W)) u_timeout (
    .clk_i     (pclk),
    .rst_i     (preset),
    .clear_i   (to_clear_s),
    .en_i      (to_en_s),
    .limit_i   (TO_LIMIT),
    .expired_o (to_expired_s)
  );

  // FSM next state plus next values of every registered output.
  always_comb begin
    state_d    = state_q;
    psel_d     = psel_q;
    penable_d  = penable_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pstrb_d    = pstrb_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    dat_d      = dat_q;
    abort_d    = abort_q;
    to_clear_s = 1'b0;
    to_en_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (wb_cyc_i && wb_stb_i) begin
          state_d   = ST_SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = wb_we_i;
          paddr_d   = wb_adr_i;
          pwdata_d  = wb_dat_i;
          pstrb_d   = wb_we_i ? wb_sel_i : PSTRB_READ;
          abort_d   = 1'b0;
        end else begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
        end
      end
      ST_SETUP: begin
        state_d    = ST_ACCESS;
        penable_d  = 1'b1;
        to_clear_s = 1'b1;
        abort_d    = abort_q | ~wb_cyc_i;
      end
      ST_ACCESS: begin
        // Once the master drops cyc the APB side still finishes, but silently.
        abort_d = abort_q | ~wb_cyc_i;
        to_en_s = ~pready;
        if (pready) begin
          state_d   = ST_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          ack_d     = ~pslverr & ~abort_d;
          err_d     = pslverr & ~abort_d;
          if (!pwrite_q && !pslverr) begin
            dat_d = prdata;
          end else begin
            dat_d = dat_q;
          end
        end else if (to_expired_s) begin
          state_d   = ST_IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          err_d     = ~abort_d;
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= ST_IDLE;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      paddr_q   <= {ADDR_WIDTH{1'b0}};
      pwdata_q  <= {DATA_WIDTH{1'b0}};
      pstrb_q   <= 4'b0000;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      stall_q   <= 1'b0;
      dat_q     <= {DATA_WIDTH{1'b0}};
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      paddr_q   <= paddr_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      stall_q   <= (state_d != ST_IDLE);
      dat_q     <= dat_d;
      abort_q   <= abort_d;
    end
  end

  assign wb_ack_o   = ack_q;
  assign wb_err_o   = err_q;
  assign wb_stall_o = stall_q;
  assign wb_dat_o   = dat_q;
  assign psel       = psel_q;
  assign penable    = penable_q;
  assign pwrite     = pwrite_q;
  assign paddr      = paddr_q;
  assign pwdata     = pwdata_q;
  assign pstrb      = pstrb_q;

endmodule

// File: tb/tb_wb_apb_bridge.sv
// Randomized bench for wb_apb_bridge against a transaction-level reference model.
module tb_wb_apb_bridge;

  localparam int TIMEOUT = 4;

  logic        pclk = 1'b0;
  logic        preset = 1'b1;
  logic        wb_cyc_i = 1'b0, wb_stb_i = 1'b0, wb_we_i = 1'b0;
  logic [2:0]  wb_adr_i = 3'd0;
  logic [3:0]  wb_sel_i = 4'd0;
  logic [31:0] wb_dat_i = 32'd0;
  logic        wb_ack_o, wb_err_o, wb_stall_o;
  logic [31:0] wb_dat_o;
  logic        psel, penable, pwrite;
  logic [2:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        pready = 1'b0;
  logic [31:0] prdata = 32'd0;
  logic        pslverr = 1'b0;

  int n_checks = 0;
  int n_fail = 0;

  // slave behaviour for the current transfer, and its storage
  int          cur_waits = 0;
  logic        cur_slverr = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] smem [2] = '{32'h0, 32'h0};

  // reference model state
  logic [31:0] ref_mem [2] = '{32'h0, 32'h0};
  logic [31:0] exp_dat = 32'h0;

  // transfer presented (stalled) behind the current one
  logic        nx_we;
  logic [2:0]  nx_adr;
  logic [3:0]  nx_sel;
  logic [31:0] nx_dat;
  int          nx_waits;
  logic        nx_slverr;

  wb_apb_bridge #(.ADDR_WIDTH(3), .DATA_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .pclk(pclk), .preset(preset),
    .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
    .wb_adr_i(wb_adr_i), .wb_sel_i(wb_sel_i), .wb_dat_i(wb_dat_i),
    .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_stall_o(wb_stall_o), .wb_dat_o(wb_dat_o),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  // APB slave: answers after cur_waits ACCESS cycles, garbage on prdata otherwise.
  always @(negedge pclk) begin
    if (psel && penable) begin
      if (acc_cnt == cur_waits) begin
        pready  = 1'b1;
        pslverr = cur_slverr;
        prdata  = smem[paddr[2]];
        if (pwrite && !cur_slverr) begin
          for (int b = 0; b < 4; b++)
            if (pstrb[b]) smem[paddr[2]][b*8 +: 8] = pwdata[b*8 +: 8];
        end
      end else begin
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = $urandom;
      end
      acc_cnt = acc_cnt + 1;
    end else begin
      pready  = 1'b0;
      pslverr = 1'b0;
      acc_cnt = 0;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic gen_next();
    nx_we     = 1'($urandom_range(0, 1));
    nx_adr    = {1'($urandom_range(0, 1)), 2'b00};
    nx_sel    = 4'($urandom);
    nx_dat    = $urandom;
    nx_waits  = $urandom_range(0, 5);
    nx_slverr = ($urandom_range(0, 4) == 0);
  endtask

  // One WB transfer, checked cycle by cycle. Starts 1 time unit after an edge.
  task automatic xfer(input logic we, input logic [2:0] adr, input logic [3:0] sel,
                      input logic [31:0] dat, input int waits, input logic slverr,
                      input logic drop, input logic hold);
    logic timed_out, exp_ack, exp_err;
    int   n_acc, idx;
    timed_out = (waits >= TIMEOUT);
    n_acc     = timed_out ? TIMEOUT : waits + 1;
    idx       = adr[2];
    cur_waits  = waits;
    cur_slverr = slverr;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we;
    wb_adr_i = adr;  wb_sel_i = sel;  wb_dat_i = dat;
    check_eq("stall_accept", wb_stall_o, 1'b0);
    @(posedge pclk); #1;
    check_eq("setup_psel", psel, 1'b1);
    check_eq("setup_penable", penable, 1'b0);
    check_eq("setup_stall", wb_stall_o, 1'b1);
    check_eq("ack_pulse_end", wb_ack_o, 1'b0);
    check_eq("err_pulse_end", wb_err_o, 1'b0);
    if (hold) begin
      wb_we_i = nx_we; wb_adr_i = nx_adr; wb_sel_i = nx_sel; wb_dat_i = nx_dat;
    end else begin
      wb_stb_i = 1'b0;
    end
    for (int k = 0; k < n_acc; k++) begin
      @(posedge pclk); #1;
      if (k == 0 && drop) wb_cyc_i = 1'b0;
      check_eq("acc_psel", psel, 1'b1);
      check_eq("acc_penable", penable, 1'b1);
      check_eq("acc_paddr", paddr, adr);
      check_eq("acc_pwrite", pwrite, we);
      check_eq("acc_pwdata", pwdata, dat);
      check_eq("acc_pstrb", pstrb, we ? sel : 4'h0);
      check_eq("acc_ack", wb_ack_o, 1'b0);
    end
    // reference: the slave only commits a completed, error-free transfer
    if (!timed_out && !slverr) begin
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) ref_mem[idx][b*8 +: 8] = dat[b*8 +: 8];
      end else begin
        exp_dat = ref_mem[idx];
      end
    end
    exp_err = !drop && (timed_out || slverr);
    exp_ack = !drop && !(timed_out || slverr);
    @(posedge pclk); #1;
    check_eq("done_psel", psel, 1'b0);
    check_eq("done_penable", penable, 1'b0);
    check_eq("done_ack", wb_ack_o, exp_ack);
    check_eq("done_err", wb_err_o, exp_err);
    check_eq("done_dat", wb_dat_o, exp_dat);
    check_eq("done_stall", wb_stall_o, 1'b0);
    if (!hold) begin
      wb_cyc_i = 1'b0;
      wb_stb_i = 1'b0;
    end
  endtask

  task automatic idle_cycle();
    @(posedge pclk); #1;
    check_eq("idle_ack", wb_ack_o, 1'b0);
    check_eq("idle_err", wb_err_o, 1'b0);
    check_eq("idle_psel", psel, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic        c_we, c_slv, c_drop, hold;
    logic [2:0]  c_adr;
    logic [3:0]  c_sel;
    logic [31:0] c_dat;
    int          c_waits;

    repeat (3) @(posedge pclk);
    #1;
    check_eq("rst_psel", psel, 1'b0);
    check_eq("rst_penable", penable, 1'b0);
    check_eq("rst_ack", wb_ack_o, 1'b0);
    check_eq("rst_err", wb_err_o, 1'b0);
    check_eq("rst_stall", wb_stall_o, 1'b0);
    check_eq("rst_dat", wb_dat_o, 32'h0);
    check_eq("rst_pstrb", pstrb, 4'h0);
    preset = 1'b0;
    idle_cycle();

    // zero-wait write, then a slow read sitting on the timeout boundary
    xfer(1'b1, 3'd0, 4'hF, 32'hDEADBEEF, 0, 1'b0, 1'b0, 1'b0);
    check_eq("slave_reg0", smem[0], 32'hDEADBEEF);
    idle_cycle();
    xfer(1'b1, 3'd4, 4'hF, 32'h12345678, 0, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    xfer(1'b0, 3'd4, 4'hA, 32'h0BADF00D, 3, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    // slave error on a read leaves wb_dat_o alone
    xfer(1'b0, 3'd0, 4'hF, 32'h0, 1, 1'b1, 1'b0, 1'b0);
    idle_cycle();
    // dead slave times out, next transfer is normal
    xfer(1'b0, 3'd0, 4'hF, 32'h0, 6, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    xfer(1'b0, 3'd0, 4'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    // back-to-back writes, second held under stall
    nx_we = 1'b1; nx_adr = 3'd4; nx_sel = 4'h3; nx_dat = 32'hA5A5C3C3;
    nx_waits = 1; nx_slverr = 1'b0;
    xfer(1'b1, 3'd0, 4'hC, 32'h77665544, 0, 1'b0, 1'b0, 1'b1);
    xfer(nx_we, nx_adr, nx_sel, nx_dat, nx_waits, nx_slverr, 1'b0, 1'b0);
    check_eq("b2b_reg0", smem[0], 32'h7766BEEF);
    check_eq("b2b_reg1", smem[1], 32'h1234C3C3);
    idle_cycle();
    // cyc dropped mid-transfer: APB write lands, no WB response
    xfer(1'b1, 3'd0, 4'hF, 32'hCAFEF00D, 2, 1'b0, 1'b1, 1'b0);
    check_eq("drop_slave", smem[0], 32'hCAFEF00D);
    idle_cycle();
    xfer(1'b0, 3'd0, 4'hF, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    idle_cycle();

    // reset in ACCESS
    cur_waits = 10; cur_slverr = 1'b0;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1;
    wb_adr_i = 3'd4; wb_sel_i = 4'hF; wb_dat_i = 32'h55AA55AA;
    @(posedge pclk); #1;
    wb_stb_i = 1'b0;
    @(posedge pclk); #1;
    check_eq("pre_rst_penable", penable, 1'b1);
    preset = 1'b1;
    @(posedge pclk); #1;
    check_eq("mid_rst_psel", psel, 1'b0);
    check_eq("mid_rst_penable", penable, 1'b0);
    check_eq("mid_rst_ack", wb_ack_o, 1'b0);
    check_eq("mid_rst_err", wb_err_o, 1'b0);
    check_eq("mid_rst_stall", wb_stall_o, 1'b0);
    check_eq("mid_rst_dat", wb_dat_o, 32'h0);
    check_eq("mid_rst_paddr", paddr, 3'd0);
    check_eq("mid_rst_pwdata", pwdata, 32'h0);
    preset = 1'b0;
    wb_cyc_i = 1'b0;
    exp_dat = 32'h0;
    idle_cycle();

    // random traffic
    gen_next();
    for (int i = 0; i < 40; i++) begin
      c_we = nx_we; c_adr = nx_adr; c_sel = nx_sel; c_dat = nx_dat;
      c_waits = nx_waits; c_slv = nx_slverr;
      c_drop = c_we && ($urandom_range(0, 7) == 0);
      gen_next();
      hold = (i < 39) && !c_drop && ($urandom_range(0, 2) == 0);
      xfer(c_we, c_adr, c_sel, c_dat, c_waits, c_slv, c_drop, hold);
      if (!hold) idle_cycle();
    end
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    idle_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
